// File: rtl/lotr_rst_ctrl.sv
// lotr_rst_ctrl: reset sequencer for the lotr core.
// A raw active-low push-button is synchronized and debounced. A hold/run
// state machine turns each accepted press into one clean, fixed-length core
// reset. Core reset is held for HOLD_CYCLES after power-on reset and after
// every button release.
//
// Optional feature (compile-time macro LOTR_RST_CTRL_SW_HOLD_EN):
//   When the macro is defined, a synchronized high level on Switch9 holds the
//   core in reset. The normal hold countdown runs once Switch9 drops.
//   When the macro is undefined, Switch9 is ignored.
module lotr_rst_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 16,
  parameter int CNT_W           = 16
) (
  input  logic       QClk,
  input  logic       RstQnnnH,
  input  logic       Button_0,
  input  logic       Switch9,
  output logic       CoreRstQnnnH,
  output logic       BtnPress,
  output logic [7:0] RstCount,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_RUN      = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Reject parameter sets the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("lotr_rst_ctrl: DEBOUNCE_CYCLES must be at least 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("lotr_rst_ctrl: HOLD_CYCLES must be at least 1");
  end
  if ((longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W)) ||
      (longint'(HOLD_CYCLES) > (longint'(1) << CNT_W))) begin : g_bad_width
    $error("lotr_rst_ctrl: CNT_W too narrow for the configured counts");
  end

  // Synchronizer stages for the raw button (idle level is high, released).
  logic             btn_p0;
  logic             btn_p1;

  // Debouncer state. 'stable' is the accepted button level.
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] dcnt;

  // Registered press pulse, which the FSM consumes.
  logic             press;

  // FSM state, hold counter and press counter.
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hcnt_next;
  logic [7:0]       rst_count;
  logic [7:0]       rst_count_next;
  logic             core_rst;

  // When high, the switch override forces the hold state.
  logic             hold_force;

  // Two-flop synchronizer on the asynchronous button input.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      btn_p0 <= 1'b1;
      btn_p1 <= 1'b1;
    end else begin
      btn_p0 <= Button_0;
      btn_p1 <= btn_p0;
    end
  end

`ifdef LOTR_RST_CTRL_SW_HOLD_EN
  logic sw_p0;
  logic sw_p1;

  // Two-flop synchronizer on the switch that forces the core into reset.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      sw_p0 <= 1'b0;
      sw_p1 <= 1'b0;
    end else begin
      sw_p0 <= Switch9;
      sw_p1 <= sw_p0;
    end
  end

  assign hold_force = sw_p1;
`else
  // The switch override is compiled out, so Switch9 drives nothing.
  logic unused_switch;
  assign unused_switch = Switch9;
  assign hold_force    = 1'b0;
`endif

  // Debouncer: a new level must persist DEBOUNCE_CYCLES cycles to be accepted.
  // Any return to the accepted level restarts the count.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      stable <= 1'b1;
      dcnt   <= '0;
    end else if (btn_p1 == stable) begin
      dcnt   <= '0;
    end else if (dcnt == DEB_LAST) begin
      stable <= btn_p1;
      dcnt   <= '0;
    end else begin
      dcnt   <= dcnt + CNT_ONE;
    end
  end

  // Generate the press pulse. It is high for the one cycle after the accepted
  // level falls.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      stable_d <= 1'b1;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= stable_d & ~stable;
    end
  end

  // Next-state logic. The switch override has priority over the button. The
  // press count advances only for presses that interrupt a running core.
  always_comb begin
    state_next     = state;
    hcnt_next      = hcnt;
    rst_count_next = rst_count;
    if (hold_force) begin
      state_next = S_HOLD;
      hcnt_next  = '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (press) begin
            state_next = S_WAIT_REL;
            hcnt_next  = '0;
          end else if (hcnt == HOLD_LAST) begin
            state_next = S_RUN;
            hcnt_next  = '0;
          end else begin
            hcnt_next  = hcnt + CNT_ONE;
          end
        end
        S_RUN: begin
          if (press) begin
            state_next     = S_WAIT_REL;
            rst_count_next = rst_count + 8'd1;
          end
        end
        S_WAIT_REL: begin
          if (stable) begin
            state_next = S_HOLD;
            hcnt_next  = '0;
          end
        end
        default: begin
          state_next = S_HOLD;
          hcnt_next  = '0;
        end
      endcase
    end
  end

  // State register. Core reset is registered from the next state, so the
  // output comes straight from a flop and cannot glitch.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      state     <= S_HOLD;
      hcnt      <= '0;
      rst_count <= '0;
      core_rst  <= 1'b1;
    end else begin
      state     <= state_next;
      hcnt      <= hcnt_next;
      rst_count <= rst_count_next;
      core_rst  <= (state_next != S_RUN);
    end
  end

  assign CoreRstQnnnH = core_rst;
  assign BtnPress     = press;
  assign RstCount     = rst_count;
  assign State        = state;

endmodule

// File: tb/tb_lotr_rst_ctrl.sv
// Self-checking bench for lotr_rst_ctrl.
// The main instance uses DEBOUNCE_CYCLES=4 and HOLD_CYCLES=3. A second
// instance uses a longer hold, so that a press can land inside the hold
// window. The expected cycle of every BtnPress pulse is queued when the
// press is driven, and is checked when the pulse appears.
module tb_lotr_rst_ctrl;

  localparam int D  = 4;
  localparam int H  = 3;
  localparam int H2 = 12;

  logic       QClk;
  logic       RstQnnnH;
  logic       Button_0;
  logic       Switch9;
  logic       CoreRstQnnnH;
  logic       BtnPress;
  logic [7:0] RstCount;
  logic [1:0] State;

  logic       rst2;
  logic       btn2;
  logic       core2;
  logic       press2;
  logic [7:0] cnt2;
  logic [1:0] state2;

  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  int exp_cnt = 0;
  int q1[$];
  int q2[$];

  lotr_rst_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .CNT_W(16)) dut (
    .QClk(QClk), .RstQnnnH(RstQnnnH), .Button_0(Button_0), .Switch9(Switch9),
    .CoreRstQnnnH(CoreRstQnnnH), .BtnPress(BtnPress), .RstCount(RstCount),
    .State(State)
  );

  lotr_rst_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H2), .CNT_W(16)) dut2 (
    .QClk(QClk), .RstQnnnH(rst2), .Button_0(btn2), .Switch9(1'b0),
    .CoreRstQnnnH(core2), .BtnPress(press2), .RstCount(cnt2),
    .State(state2)
  );

  initial QClk = 1'b0;
  always #5 QClk = ~QClk;

  always @(posedge QClk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pop the expected cycle for each press pulse when it appears.
  always @(negedge QClk) begin
    if (BtnPress === 1'b1) begin
      if (q1.size() == 0) chk("press1_unexpected", 1, 0);
      else chk("press1_cycle", cyc, q1.pop_front());
    end
    if (press2 === 1'b1) begin
      if (q2.size() == 0) chk("press2_unexpected", 1, 0);
      else chk("press2_cycle", cyc, q2.pop_front());
    end
  end

  // Drive Button_0 low for len cycles, starting from S_RUN, then release it.
  // The press pulse should come 2 sync stages + D debounce cycles + 1 register
  // stage after the drive edge. Core reset should rise one cycle later. After
  // the release, it should fall the same debounce latency plus H cycles later.
  task automatic do_press(input int len);
    int c0, c1, rise, fall;
    c1 = -1; rise = -1; fall = -1;
    @(posedge QClk); #1;
    Button_0 = 1'b0;
    c0 = cyc;
    q1.push_back(c0 + D + 3);
    for (int k = 0; k < 200 && fall < 0; k++) begin
      @(negedge QClk);
      if (CoreRstQnnnH && rise < 0) rise = cyc;
      else if (!CoreRstQnnnH && rise >= 0 && c1 >= 0) fall = cyc;
      if (fall < 0) begin
        @(posedge QClk); #1;
        if (k + 1 == len) begin
          Button_0 = 1'b1;
          c1 = cyc;
        end
      end
    end
    chk("press_rise", rise, c0 + D + 4);
    chk("press_fall", fall, c1 + D + 3 + H);
  endtask

  // Count the consecutive cycles with core reset high, starting from now.
  task automatic count_hold(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge QClk);
      if (CoreRstQnnnH) n++;
      else break;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n, c0, c1, rise, fall;
    RstQnnnH = 1'b1; Button_0 = 1'b1; Switch9 = 1'b0;
    rst2 = 1'b1; btn2 = 1'b1;

    // Reset values.
    repeat (4) @(posedge QClk);
    @(negedge QClk);
    chk("rst_core", CoreRstQnnnH, 1);
    chk("rst_press", BtnPress, 0);
    chk("rst_cnt", RstCount, 0);
    chk("rst_state", State, 0);

    // Release reset: core reset should stay high for exactly H cycles.
    @(posedge QClk); #1;
    RstQnnnH = 1'b0;
    count_hold(n);
    chk("por_hold_len", n, H);
    chk("por_state_run", State, 1);
    chk("por_cnt", RstCount, 0);

    // Long press of 20 cycles: one pulse, counted once.
    do_press(20);
    exp_cnt = (exp_cnt + 1) % 256;
    chk("long_press_cnt", RstCount, exp_cnt);
    chk("long_press_state", State, 1);

    // Five 3-cycle glitches (one short of D): none may be accepted.
    n = 0;
    for (int g = 0; g < 5; g++) begin
      @(posedge QClk); #1;
      Button_0 = 1'b0;
      repeat (3) begin
        @(negedge QClk);
        if (CoreRstQnnnH) n++;
        @(posedge QClk); #1;
      end
      Button_0 = 1'b1;
      repeat (6) begin
        @(negedge QClk);
        if (CoreRstQnnnH) n++;
        @(posedge QClk); #1;
      end
    end
    chk("glitch_core_high", n, 0);
    chk("glitch_cnt", RstCount, exp_cnt);

    // A press exactly D cycles long is accepted.
    do_press(D);
    exp_cnt = (exp_cnt + 1) % 256;
    chk("min_press_cnt", RstCount, exp_cnt);

    // Count up to 255, then wrap to 0.
    while (exp_cnt < 255) begin
      do_press(D);
      exp_cnt++;
    end
    chk("cnt_255", RstCount, 255);
    do_press(6);
    exp_cnt = 0;
    chk("cnt_wrap", RstCount, 0);

    // Hold the button in S_WAIT_REL, then pulse reset for one cycle.
    @(posedge QClk); #1;
    Button_0 = 1'b0;
    c0 = cyc;
    q1.push_back(c0 + D + 3);
    repeat (12) @(posedge QClk);
    @(negedge QClk);
    chk("held_state", State, 2);
    chk("held_core", CoreRstQnnnH, 1);
    chk("held_cnt", RstCount, 1);
    @(posedge QClk); #1;
    RstQnnnH = 1'b1;
    @(posedge QClk); #1;
    chk("midrst_core", CoreRstQnnnH, 1);
    chk("midrst_press", BtnPress, 0);
    chk("midrst_cnt", RstCount, 0);
    chk("midrst_state", State, 0);
    RstQnnnH = 1'b0;
    Button_0 = 1'b1;
    count_hold(n);
    chk("midrst_hold_len", n, H);
    chk("midrst_state_run", State, 1);
    do_press(6);
    exp_cnt = 1;
    chk("after_midrst_cnt", RstCount, exp_cnt);

    // A press inside the hold window of the long-hold instance. The hold
    // restarts only after the release, and the press is not counted.
    @(posedge QClk); #1;
    rst2 = 1'b0;
    btn2 = 1'b0;
    c0 = cyc;
    c1 = 0;
    fall = -1;
    q2.push_back(c0 + D + 3);
    for (int k = 0; k < 80 && fall < 0; k++) begin
      @(negedge QClk);
      if (!core2) fall = cyc;
      if (fall < 0) begin
        @(posedge QClk); #1;
        if (k + 1 == 20) begin
          btn2 = 1'b1;
          c1 = cyc;
        end
      end
    end
    chk("hold_restart_fall", fall, c1 + D + 3 + H2);
    chk("hold_restart_cnt", cnt2, 0);
    chk("hold_restart_state", state2, 1);

    // Switch9 high for 10 cycles while the core is running.
    @(posedge QClk); #1;
    Switch9 = 1'b1;
    c0 = cyc;
    c1 = 0;
    rise = -1; fall = -1; n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge QClk);
      if (CoreRstQnnnH) begin
        n++;
        if (rise < 0) rise = cyc;
      end else if (rise >= 0 && fall < 0) begin
        fall = cyc;
      end
      @(posedge QClk); #1;
      if (k + 1 == 10) begin
        Switch9 = 1'b0;
        c1 = cyc;
      end
    end
`ifdef LOTR_RST_CTRL_SW_HOLD_EN
    chk("sw_rise", rise, c0 + 3);
    chk("sw_fall", fall, c1 + 2 + H);
    chk("sw_high_cycles", n, (c1 + 2 + H) - (c0 + 3));
`else
    chk("sw_ignored", n, 0);
`endif
    chk("sw_cnt", RstCount, exp_cnt);

    @(negedge QClk);
    chk("press1_missing", q1.size(), 0);
    chk("press2_missing", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/lotr_rst_ctrl.md
# lotr_rst_ctrl

Reset sequencer for the lotr core on the FPGA board. Synchronizes and debounces the raw push-button, then drives the core's reset through a hold/run state machine, so a button press produces one clean, fixed-length reset of the core. Sits in the FPGA top between the board buttons/switches and the lotr instance, clocked by the 5 MHz PLL output.

## Interface
- DEBOUNCE_CYCLES, 50000: cycles the synchronized button must hold a new level before it is accepted (10 ms at 5 MHz); ≥2.
- HOLD_CYCLES, 16: cycles the core reset stays asserted after release/power-on; ≥1.
- CNT_W, 16: width of the debounce and hold counters; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES).

Ports:
- QClk  in  1  5 MHz clock, all logic rising-edge.
- RstQnnnH  in  1  synchronous active-high global reset.
- Button_0  in  1  raw board button, active-low (0 = pressed), asynchronous.
- Switch9  in  1  raw switch, asynchronous; used only under LOTR_RST_CTRL_SW_HOLD_EN.
- CoreRstQnnnH  out  1  reset to lotr core, active-high.
- BtnPress  out  1  one-cycle pulse on each accepted press.
- RstCount  out  8  number of button-initiated core resets, wraps 255→0.
- State  out  2  current state code for LED debug.

## Operation
- Synchronizer: 2 flops on Button_0 (and Switch9); reset value 1 for Button_0, 0 for Switch9.
- Debouncer: register `stable` (reset 1), counter `dcnt` (reset 0).
  - sync == stable: dcnt ← 0.
  - sync != stable, dcnt < DEBOUNCE_CYCLES-1: dcnt ← dcnt+1.
  - sync != stable, dcnt == DEBOUNCE_CYCLES-1: stable ← sync, dcnt ← 0.
  - Any glitch shorter than DEBOUNCE_CYCLES clears dcnt; no change accepted.
- BtnPress = registered pulse, high exactly the cycle after stable goes 1→0.
- FSM, State codes: S_HOLD=0, S_RUN=1, S_WAIT_REL=2; 3 unused → S_HOLD next cycle.
  - S_HOLD: hcnt counts 0..HOLD_CYCLES-1; at HOLD_CYCLES-1 → S_RUN, hcnt ← 0. BtnPress → S_WAIT_REL, hcnt ← 0 (restart).
  - S_RUN: BtnPress → S_WAIT_REL, RstCount ← RstCount+1.
  - S_WAIT_REL: stay while stable==0; stable==1 → S_HOLD, hcnt ← 0.
- CoreRstQnnnH = (State != S_RUN), Moore, glitch-free.
- RstQnnnH dominates every other input on the same cycle.

## Timing
- Reset values: CoreRstQnnnH=1, BtnPress=0, RstCount=0, State=S_HOLD, hcnt=0, dcnt=0.
- After RstQnnnH falls: CoreRstQnnnH stays 1 for exactly HOLD_CYCLES cycles, then 0.
- Press latency: Button_0 falls at edge N → stable falls at N+2+DEBOUNCE_CYCLES (±1 for async sampling) → BtnPress one cycle later → CoreRstQnnnH=1 the following cycle.
- Release: stable rises → S_HOLD next cycle → CoreRstQnnnH deasserts HOLD_CYCLES cycles later.
- Press held indefinitely: core stays in reset; no further BtnPress until release accepted.
- Press during S_HOLD: hold restarts after release; RstCount not incremented.
- RstQnnnH mid-sequence: all state returns to reset values next edge; RstCount cleared.
- RstCount 255 + press → 0.

## Configuration
- LOTR_RST_CTRL_SW_HOLD_EN defined: synchronized Switch9==1 forces State ← S_HOLD, hcnt ← 0 every cycle (core held in reset); on Switch9 falling the normal HOLD_CYCLES countdown runs. Priority: RstQnnnH > Switch9 > button. RstCount unaffected.
- Undefined: Switch9 and its synchronizer absent from logic; port left unconnected internally.

## Test plan
- DEBOUNCE_CYCLES=4, HOLD_CYCLES=3. RstQnnnH high 5 cycles then low -> CoreRstQnnnH=1 for exactly 3 cycles, then 0; State=1; RstCount=0.
- In S_RUN, Button_0 low 20 cycles then high -> one BtnPress pulse, RstCount=1, CoreRstQnnnH=1 through press and release debounce plus 3 cycles, then 0.
- In S_RUN, Button_0 low 3 cycles (glitch), repeated 5 times -> no BtnPress, CoreRstQnnnH stays 0, RstCount=0.
- RstCount preloaded to 255 via 255 presses, one more press -> RstCount=0; press during S_HOLD -> hold restarts, RstCount unchanged.
- Button held low, assert RstQnnnH one cycle -> all outputs at reset values next cycle; after release, 3-cycle hold then S_RUN, no extra BtnPress.
- With LOTR_RST_CTRL_SW_HOLD_EN: Switch9 high 10 cycles in S_RUN -> CoreRstQnnnH=1 from 3rd cycle (sync) on; Switch9 low -> 3 more cycles then 0; without the macro -> CoreRstQnnnH stays 0.
